// File: rtl/mem_result_checker_pkg.sv
// mem_result_checker_pkg
//   Shared definitions for the memory result checker: default parameter
//   values, the checker FSM state encoding and small elaboration helpers.
//   No ports; imported by every file of the block.
package mem_result_checker_pkg;

   localparam int DEF_ADDR_W         = 8;
   localparam int DEF_DATA_W         = 8;
   localparam int DEF_NUM_CHECKS     = 4;
   localparam int DEF_RUN_CYCLES     = 200000;
   localparam int DEF_TIMEOUT_CYCLES = 1000000;

   // err_count is a 5-bit saturating counter.
   localparam logic [4:0] ERR_MAX = 5'd31;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_READ   = 3'd2,
      S_CMP    = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold the values 0 .. n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_result_checker_if.sv
// mem_result_checker_if
//   Memory read port between the checker and the memory under test.
//   rd_en   : read strobe (checker -> memory)
//   rd_addr : read address (checker -> memory)
//   rd_data : read data, valid the cycle after rd_en (memory -> checker)
//   Modports: master = checker side, slave = memory side.
interface mem_result_checker_if
   import mem_result_checker_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   modport master (output rd_en, output rd_addr, input rd_data);
   modport slave  (input rd_en, input rd_addr, output rd_data);

endinterface

// File: rtl/mem_result_checker_counter.sv
// mrc_cycle_counter
//   Saturating up-counter used to time the wait phase of the checker.
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   clr   : synchronous clear to zero (wins over en)
//   en    : count enable
//   count : current value; sticks at MAX_COUNT instead of wrapping
module mrc_cycle_counter
#(
   parameter int WIDTH     = 8,
   parameter int MAX_COUNT = 255
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_COUNT);

   // NOTE: sequential state is assigned with non-blocking (<=) only, so every
   // register sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_result_checker.sv
// mem_result_checker
//   Waits for a program to finish (fixed cycle count or CPU halt with
//   timeout), then reads NUM_CHECKS memory locations and compares each with
//   its expected value, reporting pass/fail, mismatch count and the first
//   mismatch.
//   clk, reset        : clock and synchronous active-low reset
//   start             : one-cycle pulse that begins a run (IDLE only)
//   mode_halt         : sampled at start; 1 = wait for cpu_halt, 0 = fixed wait
//   cpu_halt          : CPU finished level
//   exp_addr/exp_data : packed check table, entry i at [i*W +: W]
//   mem               : memory read port (rd_en, rd_addr, rd_data)
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   pass, timeout     : run result, held until the next start
//   err_count         : mismatches seen (saturates at 31)
//   first_err_idx/_data : entry index and read value of the first mismatch
module mem_result_checker
   import mem_result_checker_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int NUM_CHECKS     = DEF_NUM_CHECKS,
   parameter int RUN_CYCLES     = DEF_RUN_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         mode_halt,
   input  logic                         cpu_halt,
   input  logic [NUM_CHECKS*ADDR_W-1:0] exp_addr,
   input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
   mem_result_checker_if.master         mem,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic                         timeout,
   output logic [4:0]                   err_count,
   output logic [3:0]                   first_err_idx,
   output logic [DATA_W-1:0]            first_err_data
);

   localparam int CNT_MAX = max_int(RUN_CYCLES, TIMEOUT_CYCLES);
   localparam int CNT_W   = cnt_width(CNT_MAX);

   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       IDX_LAST = 4'(NUM_CHECKS - 1);

   state_t            state, state_nxt;
   logic              mode_q;
   logic [3:0]        idx;
   logic [3:0]        idx_sel;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] exp_cur;
   logic              mismatch;
   logic [4:0]        err_nxt;
   logic [CNT_W-1:0]  count;

   mrc_cycle_counter #(
      .WIDTH     (CNT_W),
      .MAX_COUNT (CNT_MAX - 1)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (state == S_IDLE && start),
      .en    (state == S_WAIT),
      .count (count)
   );

   // Address for the next READ: entry 0 when leaving WAIT, idx+1 from CMP.
   // Clamped at the last entry so the slice never leaves the table.
   assign idx_sel  = (state == S_CMP && idx != IDX_LAST) ? idx + 4'd1 : idx;
   assign addr_sel = exp_addr[int'(idx_sel)*ADDR_W +: ADDR_W];
   assign exp_cur  = exp_data[int'(idx)*DATA_W +: DATA_W];
   assign mismatch = (state == S_CMP) && (mem.rd_data != exp_cur);
   assign err_nxt  = (mismatch && err_count != ERR_MAX) ? err_count + 5'd1 : err_count;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start) state_nxt = S_WAIT;
         S_WAIT: begin
            if (mode_q) begin
               // Halt is checked first so it wins over a simultaneous timeout.
               if (cpu_halt)              state_nxt = S_READ;
               else if (count == TO_LAST) state_nxt = S_FINISH;
            end else if (count == RUN_LAST) begin
               state_nxt = S_READ;
            end
         end
         S_READ:   state_nxt = S_CMP;
         S_CMP:    state_nxt = (idx == IDX_LAST) ? S_FINISH : S_READ;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // NOTE: all result registers are reset, not only the state, because the
   // outputs are required to read 0 while reset is applied.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= S_IDLE;
         mode_q         <= 1'b0;
         idx            <= '0;
         rd_addr_q      <= '0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q         <= mode_halt;
                  idx            <= '0;
                  pass           <= 1'b0;
                  timeout        <= 1'b0;
                  err_count      <= '0;
                  first_err_idx  <= '0;
                  first_err_data <= '0;
               end
            end
            S_WAIT: begin
               if (state_nxt == S_READ)   rd_addr_q <= addr_sel;
               if (state_nxt == S_FINISH) timeout   <= 1'b1;
            end
            S_CMP: begin
               err_count <= err_nxt;
               // err_count never returns to 0 once set, so 0 marks "first".
               if (mismatch && err_count == '0) begin
                  first_err_idx  <= idx;
                  first_err_data <= mem.rd_data;
               end
               if (state_nxt == S_READ) begin
                  idx       <= idx_sel;
                  rd_addr_q <= addr_sel;
               end else begin
                  // Result is valid in the same cycle as the done pulse.
                  pass <= (err_nxt == '0) && !timeout;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem.rd_en   = (state == S_READ);
   assign mem.rd_addr = rd_addr_q;
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_FINISH);

endmodule

// File: tb/tb_mem_result_checker.sv
// tb_mem_result_checker
//   Directed-vector bench for mem_result_checker with RUN_CYCLES=50 and
//   TIMEOUT_CYCLES=100. A behavioural memory answers reads one cycle after
//   rd_en. Latencies are measured from the cycle in which start is high to
//   the cycle in which done is high.
module tb_mem_result_checker;
   import mem_result_checker_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int NCHK   = 4;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   start;
   logic                   mode_halt;
   logic                   cpu_halt;
   logic [NCHK*ADDR_W-1:0] exp_addr;
   logic [NCHK*DATA_W-1:0] exp_data;
   logic                   busy, done, pass, timeout;
   logic [4:0]             err_count;
   logic [3:0]             first_err_idx;
   logic [DATA_W-1:0]      first_err_data;

   logic [DATA_W-1:0] mem [256];

   int vec_count   = 0;
   int miscompares = 0;
   int cyc         = 0;
   int start_cyc   = 0;
   int lat         = 0;
   bit rd_seen     = 1'b0;
   bit done_seen   = 1'b0;

   mem_result_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

   mem_result_checker #(
      .ADDR_W         (ADDR_W),
      .DATA_W         (DATA_W),
      .NUM_CHECKS     (NCHK),
      .RUN_CYCLES     (50),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .mode_halt      (mode_halt),
      .cpu_halt       (cpu_halt),
      .exp_addr       (exp_addr),
      .exp_data       (exp_data),
      .mem            (mem_if.master),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .timeout        (timeout),
      .err_count      (err_count),
      .first_err_idx  (first_err_idx),
      .first_err_data (first_err_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (mem_if.rd_en) mem_if.rd_data <= mem[mem_if.rd_addr];

   always @(negedge clk) begin
      if (mem_if.rd_en) rd_seen = 1'b1;
      if (done)         done_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vec_count++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic mode);
      tick(1);
      mode_halt = mode;
      start     = 1'b1;
      start_cyc = cyc;
      tick(1);
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      while (!done && n < limit) begin
         tick(1);
         n++;
      end
      lat = cyc - start_cyc;
      check({tag, "_done_seen"}, 32'(done), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"},   32'(mem_if.rd_en),   32'd0);
      check({tag, "_rd_addr"}, 32'(mem_if.rd_addr), 32'd0);
      check({tag, "_busy"},    32'(busy),           32'd0);
      check({tag, "_done"},    32'(done),           32'd0);
      check({tag, "_pass"},    32'(pass),           32'd0);
      check({tag, "_timeout"}, 32'(timeout),        32'd0);
      check({tag, "_err"},     32'(err_count),      32'd0);
      check({tag, "_fidx"},    32'(first_err_idx),  32'd0);
      check({tag, "_fdata"},   32'(first_err_data), 32'd0);
   endtask

   task automatic load_good_mem();
      mem[8'h10] = 8'h0A;
      mem[8'h20] = 8'h0B;
      mem[8'h30] = 8'h0C;
      mem[8'hFF] = 8'h0D;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      load_good_mem();
      reset     = 1'b0;
      start     = 1'b0;
      mode_halt = 1'b0;
      cpu_halt  = 1'b0;
      exp_addr  = {8'hFF, 8'h30, 8'h20, 8'h10};
      exp_data  = {8'h0D, 8'h0C, 8'h0B, 8'h0A};

      // Reset state.
      tick(3);
      check_all_zero("reset");
      reset = 1'b1;
      tick(2);

      // Fixed mode, all match; a halt-mode start mid-run must be ignored.
      pulse_start(1'b0);
      tick(5);
      mode_halt = 1'b1;
      start     = 1'b1;
      tick(1);
      start     = 1'b0;
      check("fix_busy", 32'(busy), 32'd1);
      wait_done("fix", 200);
      check("fix_latency", 32'(lat),       32'd59);
      check("fix_pass",    32'(pass),      32'd1);
      check("fix_err",     32'(err_count), 32'd0);
      check("fix_timeout", 32'(timeout),   32'd0);
      tick(1);
      check("fix_done_pulse", 32'(done), 32'd0);
      check("fix_idle_busy",  32'(busy), 32'd0);
      check("fix_pass_held",  32'(pass), 32'd1);

      // Halt mode, halt in cycle 30, entry 2 reads 0x0C against 0x0D.
      exp_data[23:16] = 8'h0D;
      pulse_start(1'b1);
      check("halt_pass_cleared", 32'(pass), 32'd0);
      tick(29);
      cpu_halt = 1'b1;
      wait_done("halt", 200);
      cpu_halt = 1'b0;
      check("halt_latency", 32'(lat),            32'd39);
      check("halt_pass",    32'(pass),           32'd0);
      check("halt_err",     32'(err_count),      32'd1);
      check("halt_fidx",    32'(first_err_idx),  32'd2);
      check("halt_fdata",   32'(first_err_data), 32'h0C);
      check("halt_timeout", 32'(timeout),        32'd0);

      // Halt mode, halt never comes: timeout after 100 wait cycles, no reads.
      exp_data[23:16] = 8'h0C;
      tick(1);
      rd_seen = 1'b0;
      pulse_start(1'b1);
      check("to_err_cleared", 32'(err_count), 32'd0);
      wait_done("to", 300);
      check("to_latency", 32'(lat),     32'd101);
      check("to_timeout", 32'(timeout), 32'd1);
      check("to_pass",    32'(pass),    32'd0);
      check("to_no_read", 32'(rd_seen), 32'd0);

      // Halt arrives in the very cycle the timeout limit is reached.
      pulse_start(1'b1);
      tick(99);
      cpu_halt = 1'b1;
      wait_done("tie", 200);
      cpu_halt = 1'b0;
      check("tie_latency", 32'(lat),     32'd109);
      check("tie_timeout", 32'(timeout), 32'd0);
      check("tie_pass",    32'(pass),    32'd1);

      // Entries 1 and 3 mismatch.
      mem[8'h20] = 8'h5B;
      mem[8'hFF] = 8'h7D;
      pulse_start(1'b0);
      wait_done("two", 200);
      check("two_latency", 32'(lat),            32'd59);
      check("two_err",     32'(err_count),      32'd2);
      check("two_fidx",    32'(first_err_idx),  32'd1);
      check("two_fdata",   32'(first_err_data), 32'h5B);
      check("two_pass",    32'(pass),           32'd0);

      // Reset during the third READ, after one mismatch was already recorded.
      pulse_start(1'b0);
      begin
         int n = 0;
         while (!(mem_if.rd_en && mem_if.rd_addr == 8'h30) && n < 200) begin
            tick(1);
            n++;
         end
      end
      check("rst_in_read", 32'(mem_if.rd_en), 32'd1);
      check("rst_pre_err", 32'(err_count),    32'd1);
      done_seen = 1'b0;
      reset     = 1'b0;
      tick(1);
      check_all_zero("rst_mid");
      tick(1);
      reset = 1'b1;
      tick(70);
      check("rst_no_done", 32'(done_seen), 32'd0);
      check("rst_idle",    32'(busy),      32'd0);

      load_good_mem();
      pulse_start(1'b0);
      wait_done("after_rst", 200);
      check("after_rst_latency", 32'(lat),       32'd59);
      check("after_rst_pass",    32'(pass),      32'd1);
      check("after_rst_err",     32'(err_count), 32'd0);

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_result_checker.md
MEM_RESULT_CHECKER -- requirements
Module: mem_result_checker

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- NUM_CHECKS, 4, number of (address, expected value) pairs checked; range 1..16.
- RUN_CYCLES, 200000, cycles to wait in fixed-time mode.
- TIMEOUT_CYCLES, 1000000, maximum wait in halt mode.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock; all logic on the rising edge.
- reset, in, 1, synchronous, active-low reset.
- start, in, 1, one-cycle pulse that begins a check run.
- mode_halt, in, 1, sampled at start: 1 = wait for cpu_halt, 0 = wait RUN_CYCLES.
- cpu_halt, in, 1, level from the CPU indicating the program has finished.
- exp_addr, in, NUM_CHECKS*ADDR_W, packed addresses; entry i sits at bits [i*ADDR_W +: ADDR_W].
- exp_data, in, NUM_CHECKS*DATA_W, packed expected values; same packing as exp_addr.
- rd_en, out, 1, memory read strobe.
- rd_addr, out, ADDR_W, memory read address.
- rd_data, in, DATA_W, read data, valid exactly 1 cycle after rd_en.
- busy, out, 1, high from the cycle after start until done.
- done, out, 1, one-cycle pulse at the end of a run.
- pass, out, 1, high when no mismatch and no timeout; held until the next start.
- timeout, out, 1, high when the halt wait expired; held until the next start.
- err_count, out, 5, number of mismatches.
- first_err_idx, out, 4, index of the first mismatching entry.
- first_err_data, out, DATA_W, rd_data value for that first mismatch.

Function
REQ-003 The block SHALL implement an FSM with states IDLE, WAIT, READ, CMP, FINISH.
REQ-004 In IDLE, start=1 SHALL latch mode_halt, clear the cycle counter, check index, err_count, pass, timeout and first_err_*, then enter WAIT.
REQ-005 In WAIT with mode_halt=0, the block SHALL leave for READ when the counter reaches RUN_CYCLES-1; cpu_halt SHALL be ignored.
REQ-006 In WAIT with mode_halt=1, the block SHALL leave for READ in the first cycle cpu_halt=1.
- If the counter reaches TIMEOUT_CYCLES-1 first, the block SHALL set timeout and go directly to FINISH with no reads.
- If cpu_halt=1 in the same cycle the counter hits the limit, halt SHALL win.
REQ-007 In READ, the block SHALL drive rd_en=1 and rd_addr=exp_addr[idx] for exactly one cycle, then enter CMP.
REQ-008 In CMP, the block SHALL compare rd_data with exp_data[idx].
- On mismatch, err_count SHALL increment (saturating at 31).
- On the first mismatch only, the block SHALL capture first_err_idx=idx and first_err_data=rd_data.
REQ-009 From CMP, the block SHALL go to READ with idx+1 if idx<NUM_CHECKS-1, else to FINISH. All checks SHALL run; the block SHALL not stop early on a mismatch.
REQ-010 Read latency per check SHALL be 2 cycles; total check phase SHALL be 2*NUM_CHECKS cycles.
REQ-011 FINISH SHALL last one cycle: done=1, pass=(err_count==0 && !timeout), then return to IDLE.
REQ-012 busy SHALL be high in WAIT, READ, CMP and FINISH.
REQ-013 start SHALL be ignored in any state other than IDLE.
REQ-014 rd_en SHALL be 0 outside READ; rd_addr SHALL hold its last value.
REQ-015 The counter SHALL be wide enough for max(RUN_CYCLES, TIMEOUT_CYCLES) and SHALL not wrap.

Reset
REQ-016 While reset=0 at a clock edge, the FSM SHALL go to IDLE.
- All outputs SHALL reset to 0: rd_en, rd_addr, busy, done, pass, timeout, err_count, first_err_idx, first_err_data.
REQ-017 Reset asserted mid-run SHALL abort the run with no done pulse; a new start is required after release.

Structure
REQ-018 The FSM state encoding and the default parameter values SHALL live in the shared project package.
REQ-019 The block SHALL be one module; the one natural sub-module is a saturating cycle counter, mrc_cycle_counter.

Verification
REQ-020 Fixed mode, RUN_CYCLES=50, all 4 entries match (addr 255 -> 0x0D):
- done pulses 50+8+1 cycles after start; pass=1; err_count=0.
REQ-021 Halt mode, cpu_halt raised at cycle 30, entry 2 reads 0x0C vs expected 0x0D:
- pass=0; err_count=1; first_err_idx=2; first_err_data=0x0C.
REQ-022 Halt mode, cpu_halt never asserted, TIMEOUT_CYCLES=100:
- timeout=1 and pass=0 at cycle 100; rd_en never asserted.
REQ-023 Entries 1 and 3 mismatch:
- err_count=2; first_err_idx=1.
REQ-024 Reset pulled low during READ:
- all outputs 0 next cycle; no done pulse.
- A new start then completes normally with pass=1.
